// File: rtl/sv_la_seq.sv
// Limb-serial long-arithmetic unit: operands latched on start, LIMB_W bits processed per cycle.
// Define SV_LA_MODMUL_EN to build op 8, the interleaved (a*b) mod q; otherwise op 8 is illegal.
module sv_la_seq #(
  parameter int BLOCK_SIZE = 1024,
  parameter int LIMB_W     = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [3:0]                   op_i,
  input  logic [BLOCK_SIZE/8-1:0][7:0] q_i,
  input  logic [BLOCK_SIZE/8-1:0][7:0] a_i,
  input  logic [BLOCK_SIZE/8-1:0][7:0] b_i,
  output logic                         ready_o,
  output logic                         done_o,
  output logic [BLOCK_SIZE/8-1:0][7:0] r_o,
  output logic                         c_o,
  output logic                         err_o
);
  localparam int NLIMB = BLOCK_SIZE / LIMB_W;
  localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PASS1, S_PASS2, S_MUL, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [BLOCK_SIZE-1:0] q_q, q_d, a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cy_q, cy_d, flag_q, flag_d, c_q, c_d, err_q, err_d;

  int                    lbase;
  logic                  last;
  logic [LIMB_W-1:0]     ql, al, bl, rl, xl, yl;
  logic [LIMB_W:0]       sum;
`ifdef SV_LA_MODMUL_EN
  logic [BLOCK_SIZE:0]   mt;
  int                    bidx;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    q_d     = q_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    flag_d  = flag_q;
    c_d     = c_q;
    err_d   = err_q;
`ifdef SV_LA_MODMUL_EN
    mt      = '0;
    bidx    = 0;
`endif
    lbase = 0;
    // Shift right walks MSB limb first so the carried bit comes from the limb above.
    if (state_q == S_PASS1 || state_q == S_PASS2)
      lbase = ((op_q == 4'd2) ? (NLIMB - 1 - int'(cnt_q)) : int'(cnt_q)) * LIMB_W;
    last = (cnt_q == CNT_W'(NLIMB - 1));
    ql   = q_q[lbase +: LIMB_W];
    al   = a_q[lbase +: LIMB_W];
    bl   = b_q[lbase +: LIMB_W];
    rl   = r_q[lbase +: LIMB_W];

    // Subtraction is x + ~y with carry-in 1, so cy_q=1 means "no borrow".
    xl = rl;
    yl = '0;
    if (state_q == S_PASS2) begin
      yl = (op_q == 4'd3) ? ~ql : (flag_q ? ql : '0);
    end else begin
      case (op_q)
        4'd0:    begin xl = bl; yl = '1;  end
        4'd1:    begin xl = bl; yl = '0;  end
        4'd3:    begin xl = al; yl = bl;  end
        4'd4:    begin xl = al; yl = ~bl; end
        default: ;
      endcase
    end
    sum = {1'b0, xl} + {1'b0, yl} + {{LIMB_W{1'b0}}, cy_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d   = op_i;
          q_d    = q_i;
          a_d    = a_i;
          b_d    = b_i;
          r_d    = '0;
          c_d    = 1'b0;
          err_d  = 1'b0;
          cnt_d  = '0;
          flag_d = 1'b0;
          cy_d   = (op_i == 4'd1) || (op_i == 4'd4) || (op_i == 4'd6);
          if (op_i <= 4'd7) begin
            state_d = S_PASS1;
`ifdef SV_LA_MODMUL_EN
          end else if (op_i == 4'd8) begin
            state_d = S_MUL;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_PASS1: begin
        case (op_q)
          4'd2: begin
            r_d[lbase +: LIMB_W] = {cy_q, bl[LIMB_W-1:1]};
            cy_d                 = bl[0];
          end
          4'd5: r_d[lbase +: LIMB_W] = al;
          4'd6: cy_d = cy_q & (al == bl);
          4'd7: ;
          default: begin
            r_d[lbase +: LIMB_W] = sum[LIMB_W-1:0];
            cy_d                 = sum[LIMB_W];
          end
        endcase
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          c_d     = (op_q == 4'd6) ? (cy_q & (al == bl)) :
                    (op_q == 4'd7) ? b_q[0] : 1'b0;
          if (op_q == 4'd3) begin
            state_d = S_PASS2;
            flag_d  = sum[LIMB_W];
            cy_d    = 1'b1;
          end else if (op_q == 4'd4) begin
            state_d = S_PASS2;
            flag_d  = ~sum[LIMB_W];
            cy_d    = 1'b0;
          end
        end
      end
      S_PASS2: begin
        // Modular add keeps s in r and builds s-q in the spent a register.
        if (op_q == 4'd3) a_d[lbase +: LIMB_W] = sum[LIMB_W-1:0];
        else              r_d[lbase +: LIMB_W] = sum[LIMB_W-1:0];
        cy_d  = sum[LIMB_W];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (op_q == 4'd3 && (flag_q | sum[LIMB_W])) r_d = a_d;
        end
      end
`ifdef SV_LA_MODMUL_EN
      S_MUL: begin
        bidx = BLOCK_SIZE - 1 - int'(cnt_q[CNT_W-1:1]);
        if (!cnt_q[0])        mt = {r_q, 1'b0};
        else if (b_q[bidx])   mt = {1'b0, r_q} + {1'b0, a_q};
        else                  mt = {1'b0, r_q};
        if (mt >= {1'b0, q_q}) mt = mt - {1'b0, q_q};
        r_d   = mt[BLOCK_SIZE-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(2 * BLOCK_SIZE - 1)) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      q_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      flag_q  <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      flag_q  <= flag_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign r_o     = r_q;
  assign c_o     = c_q;
  assign err_o   = err_q;
endmodule
